shift_unit_arbiter: RTL and testbench

//  Shares one 64-bit shift datapath (SLL/ROTL/SRL/SRA/ROTR) between two requesters,
//  e.g. the multi-cycle ALU shift path (req0) and the mul/div unit (req1).

---
 rtl/shift_unit_arbiter_if.sv | 42 ++++
 rtl/shift_unit_arbiter.sv | 139 +++++++++++++
 tb/tb_shift_unit_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_unit_arbiter_if.sv
// Request/result bundle for shift_unit_arbiter: two requester ports, one result port.
// slave is the arbiter side, master is the requester/consumer side.
interface shift_unit_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [2:0]  req0_op;
    logic        req0_word;
    logic [5:0]  req0_amount;
    logic [63:0] req0_data;

    logic        req1_valid;
    logic        req1_ready;
    logic [2:0]  req1_op;
    logic        req1_word;
    logic [5:0]  req1_amount;
    logic [63:0] req1_data;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_id;
    logic        out_err;
    logic        busy;

    modport slave (
        input  req0_valid, req0_op, req0_word, req0_amount, req0_data,
        output req0_ready,
        input  req1_valid, req1_op, req1_word, req1_amount, req1_data,
        output req1_ready,
        output out_valid, out_data, out_id, out_err, busy,
        input  out_ready
    );

    modport master (
        output req0_valid, req0_op, req0_word, req0_amount, req0_data,
        input  req0_ready,
        output req1_valid, req1_op, req1_word, req1_amount, req1_data,
        input  req1_ready,
        input  out_valid, out_data, out_id, out_err, busy,
        output out_ready
    );
endinterface

// File: rtl/shift_unit_arbiter.sv
// Two-requester arbiter in front of a shared 64-bit shift/rotate datapath with
// MIPS64-style 32-bit word operations. IDLE -> EXEC -> HOLD handshake per request.
module shift_unit_arbiter #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    shift_unit_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t      state, nextState;
    logic        lastGrant;
    logic        anyValid;
    logic        grantId;
    logic        accept;

    logic [2:0]  opR;
    logic        wordR;
    logic [5:0]  amtR;
    logic [63:0] dataR;
    logic        idR;

    logic [63:0] outDataR;
    logic        outErrR;

    logic [63:0] calcData;
    logic        calcErr;
    logic [127:0] dwPair;
    logic [63:0]  wPair;
    logic [31:0]  word32;

    always_comb begin
        anyValid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid)
            grantId = RR_ENABLE ? ~lastGrant : 1'b0;
        else
            grantId = ~bus.req0_valid;
        // reset_n gating keeps ready low while reset is asserted with valid held high
        accept = (state == IDLE) && anyValid && reset_n;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (anyValid) nextState = EXEC;
            EXEC:    nextState = HOLD;
            HOLD:    if (bus.out_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid  = (state == HOLD);
        bus.busy       = (state != IDLE);
        bus.req0_ready = accept && !grantId;
        bus.req1_ready = accept && grantId;
        bus.out_data   = outDataR;
        bus.out_err    = outErrR;
        bus.out_id     = idR;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lastGrant <= 1'b1;
            opR       <= '0;
            wordR     <= 1'b0;
            amtR      <= '0;
            dataR     <= '0;
            idR       <= 1'b0;
            outDataR  <= '0;
            outErrR   <= 1'b0;
        end else begin
            if (accept) begin
                lastGrant <= grantId;
                idR       <= grantId;
                opR       <= grantId ? bus.req1_op     : bus.req0_op;
                wordR     <= grantId ? bus.req1_word   : bus.req0_word;
                amtR      <= grantId ? bus.req1_amount : bus.req0_amount;
                dataR     <= grantId ? bus.req1_data   : bus.req0_data;
            end
            if (state == EXEC) begin
                outDataR <= calcData;
                outErrR  <= calcErr;
            end
        end
    end

    // Rotates shift a doubled operand and keep the window that wrapped around.
    always_comb begin
        calcData = '0;
        calcErr  = 1'b0;
        dwPair   = '0;
        wPair    = '0;
        word32   = '0;
        if (!wordR) begin
            case (opR)
                3'd0: calcData = dataR << amtR;
                3'd1: begin
                    dwPair   = {dataR, dataR} << amtR;
                    calcData = dwPair[127:64];
                end
                3'd2: calcData = dataR >> amtR;
                3'd3: calcData = $signed(dataR) >>> amtR;
                3'd4: begin
                    dwPair   = {dataR, dataR} >> amtR;
                    calcData = dwPair[63:0];
                end
                default: calcErr = 1'b1;
            endcase
        end else begin
            case (opR)
                3'd0: word32 = dataR[31:0] << amtR[4:0];
                3'd1: begin
                    wPair  = {dataR[31:0], dataR[31:0]} << amtR[4:0];
                    word32 = wPair[63:32];
                end
                3'd2: word32 = dataR[31:0] >> amtR[4:0];
                3'd3: word32 = $signed(dataR[31:0]) >>> amtR[4:0];
                3'd4: begin
                    wPair  = {dataR[31:0], dataR[31:0]} >> amtR[4:0];
                    word32 = wPair[31:0];
                end
                default: calcErr = 1'b1;
            endcase
            if (!calcErr)
                calcData = {{32{word32[31]}}, word32};
        end
    end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench for shift_unit_arbiter: round-robin and fixed-priority instances
// share clock and reset; each scenario task checks its own expectations.
module tb_shift_unit_arbiter;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clock = ~clock;

    shift_unit_arbiter_if ifRr();
    shift_unit_arbiter_if ifFp();

    shift_unit_arbiter #(.RR_ENABLE(1'b1)) dutRr (.clock(clock), .reset_n(reset_n), .bus(ifRr.slave));
    shift_unit_arbiter #(.RR_ENABLE(1'b0)) dutFp (.clock(clock), .reset_n(reset_n), .bus(ifFp.slave));

    task automatic clearInputs();
        ifRr.req0_valid = 0; ifRr.req0_op = 0; ifRr.req0_word = 0; ifRr.req0_amount = 0; ifRr.req0_data = 0;
        ifRr.req1_valid = 0; ifRr.req1_op = 0; ifRr.req1_word = 0; ifRr.req1_amount = 0; ifRr.req1_data = 0;
        ifRr.out_ready = 0;
        ifFp.req0_valid = 0; ifFp.req0_op = 0; ifFp.req0_word = 0; ifFp.req0_amount = 0; ifFp.req0_data = 0;
        ifFp.req1_valid = 0; ifFp.req1_op = 0; ifFp.req1_word = 0; ifFp.req1_amount = 0; ifFp.req1_data = 0;
        ifFp.out_ready = 0;
    endtask

    task automatic driveReq(input bit n, input logic [2:0] op, input logic word,
                            input logic [5:0] amt, input logic [63:0] data);
        if (!n) begin
            ifRr.req0_op = op; ifRr.req0_word = word; ifRr.req0_amount = amt; ifRr.req0_data = data;
            ifRr.req0_valid = 1;
        end else begin
            ifRr.req1_op = op; ifRr.req1_word = word; ifRr.req1_amount = amt; ifRr.req1_data = data;
            ifRr.req1_valid = 1;
        end
    endtask

    task automatic waitReady(input bit n, output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((n ? ifRr.req1_ready : ifRr.req0_ready) === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic waitValid(output bit ok, output int lat);
        ok = 0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            lat++;
            if (ifRr.out_valid === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Issue one request on the round-robin instance and consume its result.
    task automatic runOp(input bit n, input logic [2:0] op, input logic word, input logic [5:0] amt,
                         input logic [63:0] data, output logic [63:0] d, output logic id,
                         output logic err, output int lat, output bit ok);
        bit gOk, vOk;
        d = 'x; id = 'x; err = 'x; lat = -1;
        driveReq(n, op, word, amt, data);
        waitReady(n, gOk);
        if (!gOk) begin
            ok = 0;
            ifRr.req0_valid = 0; ifRr.req1_valid = 0;
            return;
        end
        @(posedge clock); #1;
        if (!n) ifRr.req0_valid = 0; else ifRr.req1_valid = 0;
        waitValid(vOk, lat);
        ok = vOk;
        d = ifRr.out_data; id = ifRr.out_id; err = ifRr.out_err;
        ifRr.out_ready = 1;
        @(posedge clock); #1;
        ifRr.out_ready = 0;
        @(negedge clock);
    endtask

    task automatic applyReset();
        reset_n = 0;
        clearInputs();
        repeat (2) @(negedge clock);
        reset_n = 1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        clearInputs();
        reset_n = 0;
        repeat (2) @(negedge clock);
        total++;
        if ({ifRr.out_valid, ifRr.busy, ifRr.req0_ready, ifRr.req1_ready, ifRr.out_id, ifRr.out_err} !== 6'b0
            || ifRr.out_data !== 64'h0) begin
            bad++; $display("FAIL reset_rr got v=%b b=%b d=%h id=%b err=%b want all 0",
                            ifRr.out_valid, ifRr.busy, ifRr.out_data, ifRr.out_id, ifRr.out_err);
        end
        total++;
        if ({ifFp.out_valid, ifFp.busy, ifFp.out_id, ifFp.out_err} !== 4'b0 || ifFp.out_data !== 64'h0) begin
            bad++; $display("FAIL reset_fp got v=%b b=%b d=%h want all 0", ifFp.out_valid, ifFp.busy, ifFp.out_data);
        end
        reset_n = 1;
        repeat (2) @(negedge clock);
        total++;
        if (ifRr.out_valid !== 1'b0 || ifRr.busy !== 1'b0) begin
            bad++; $display("FAIL reset_release got v=%b b=%b want 0 0", ifRr.out_valid, ifRr.busy);
        end
    endtask

    task automatic test_sll();
        logic [63:0] d; logic id, err; int lat; bit ok;
        runOp(0, 3'd0, 0, 6'd4, 64'h0000_0000_0000_00F1, d, id, err, lat, ok);
        total++;
        if (ok !== 1'b1 || lat != 2) begin
            bad++; $display("FAIL sll_latency got ok=%0d lat=%0d want ok=1 lat=2", ok, lat);
        end
        total++;
        if (d !== 64'hF10 || id !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL sll_result got d=%h id=%b err=%b want d=%h id=0 err=0", d, id, err, 64'hF10);
        end
        total++;
        if (ifRr.out_valid !== 1'b0) begin
            bad++; $display("FAIL sll_valid_drop got %b want 0", ifRr.out_valid);
        end
    endtask

    task automatic test_dword();
        logic [2:0]  ops [5] = '{3'd3, 3'd4, 3'd1, 3'd3, 3'd2};
        logic [5:0]  amts[5] = '{6'd63, 6'd8, 6'd4, 6'd0, 6'd63};
        logic [63:0] dats[5] = '{64'h8000_0000_0000_0000, 64'h0123_4567_89AB_CDEF,
                                 64'h0123_4567_89AB_CDEF, 64'h8765_4321_0FED_CBA9,
                                 64'hFFFF_FFFF_FFFF_FFFF};
        logic [63:0] exps[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hEF01_2345_6789_ABCD,
                                 64'h1234_5678_9ABC_DEF0, 64'h8765_4321_0FED_CBA9,
                                 64'h0000_0000_0000_0001};
        logic [63:0] d; logic id, err; int lat; bit ok;
        for (int i = 0; i < 5; i++) begin
            runOp(1, ops[i], 0, amts[i], dats[i], d, id, err, lat, ok);
            total++;
            if (ok !== 1'b1 || d !== exps[i] || id !== 1'b1 || err !== 1'b0 || lat != 2) begin
                bad++; $display("FAIL dword_%0d got ok=%0d lat=%0d d=%h id=%b err=%b want d=%h id=1 err=0 lat=2",
                                i, ok, lat, d, id, err, exps[i]);
            end
        end
    endtask

    task automatic test_word();
        logic [2:0]  ops [6] = '{3'd0, 3'd2, 3'd3, 3'd1, 3'd4, 3'd0};
        logic [5:0]  amts[6] = '{6'd33, 6'd4, 6'd4, 6'd4, 6'd36, 6'd0};
        logic [63:0] dats[6] = '{64'hDEAD_BEEF_4000_0000, 64'h0000_0000_8000_0000,
                                 64'h0000_0000_8000_0000, 64'hFFFF_0000_1234_5678,
                                 64'h0000_0000_0000_0001, 64'hAAAA_AAAA_8765_4321};
        logic [63:0] exps[6] = '{64'hFFFF_FFFF_8000_0000, 64'h0000_0000_0800_0000,
                                 64'hFFFF_FFFF_F800_0000, 64'h0000_0000_2345_6781,
                                 64'h0000_0000_1000_0000, 64'hFFFF_FFFF_8765_4321};
        logic [63:0] d; logic id, err; int lat; bit ok;
        for (int i = 0; i < 6; i++) begin
            runOp(0, ops[i], 1, amts[i], dats[i], d, id, err, lat, ok);
            total++;
            if (ok !== 1'b1 || d !== exps[i] || id !== 1'b0 || err !== 1'b0) begin
                bad++; $display("FAIL word_%0d got ok=%0d d=%h id=%b err=%b want d=%h id=0 err=0",
                                i, ok, d, id, err, exps[i]);
            end
        end
    endtask

    task automatic test_arbitration();
        int g;
        logic expRr[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        applyReset();
        ifRr.req0_valid = 1; ifRr.req0_data = 64'h1;
        ifRr.req1_valid = 1; ifRr.req1_data = 64'h2;
        ifRr.out_ready = 1;
        g = 0;
        for (int i = 0; i < 30 && g < 4; i++) begin
            #1;
            total++;
            if (ifRr.req0_ready === 1'b1 && ifRr.req1_ready === 1'b1) begin
                bad++; $display("FAIL rr_both_ready got 1 1 want one-hot");
            end
            if (ifRr.req0_ready === 1'b1 || ifRr.req1_ready === 1'b1) begin
                total++;
                if (ifRr.req1_ready !== expRr[g] || ifRr.busy !== 1'b0) begin
                    bad++; $display("FAIL rr_grant_%0d got r1=%b busy=%b want r1=%b busy=0",
                                    g, ifRr.req1_ready, ifRr.busy, expRr[g]);
                end
                g++;
            end else begin
                total++;
                if (ifRr.busy !== 1'b1) begin
                    bad++; $display("FAIL rr_busy got %b want 1", ifRr.busy);
                end
            end
            @(negedge clock);
        end
        total++;
        if (g != 4) begin
            bad++; $display("FAIL rr_grant_count got %0d want 4", g);
        end
        ifRr.req0_valid = 0; ifRr.req1_valid = 0;
        repeat (4) @(negedge clock);
        ifRr.out_ready = 0;

        ifFp.req0_valid = 1; ifFp.req1_valid = 1; ifFp.out_ready = 1;
        g = 0;
        for (int i = 0; i < 30 && g < 3; i++) begin
            #1;
            if (ifFp.req0_ready === 1'b1 || ifFp.req1_ready === 1'b1) begin
                total++;
                if (ifFp.req0_ready !== 1'b1 || ifFp.req1_ready !== 1'b0) begin
                    bad++; $display("FAIL fp_grant_%0d got r0=%b r1=%b want r0=1 r1=0",
                                    g, ifFp.req0_ready, ifFp.req1_ready);
                end
                g++;
            end else begin
                total++;
                if (ifFp.busy !== 1'b1) begin
                    bad++; $display("FAIL fp_busy got %b want 1", ifFp.busy);
                end
            end
            @(negedge clock);
        end
        total++;
        if (g != 3) begin
            bad++; $display("FAIL fp_grant_count got %0d want 3", g);
        end
        ifFp.req0_valid = 0; ifFp.req1_valid = 0;
        repeat (4) @(negedge clock);
        ifFp.out_ready = 0;
    endtask

    task automatic test_hold();
        bit ok; int lat;
        logic [63:0] d; logic id, err;
        driveReq(0, 3'd1, 0, 6'd1, 64'h8000_0000_0000_0001);
        waitReady(0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL hold_grant0 got timeout want ready"); end
        @(posedge clock); #1;
        ifRr.req0_valid = 0;
        driveReq(1, 3'd2, 0, 6'd8, 64'h0000_0000_0000_FF00);
        waitValid(ok, lat);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (ifRr.out_valid !== 1'b1 || ifRr.out_data !== 64'h3 || ifRr.out_id !== 1'b0
                || ifRr.req1_ready !== 1'b0 || ifRr.out_err !== 1'b0) begin
                bad++; $display("FAIL hold_stable_%0d got v=%b d=%h id=%b r1=%b want v=1 d=3 id=0 r1=0",
                                i, ifRr.out_valid, ifRr.out_data, ifRr.out_id, ifRr.req1_ready);
            end
            @(negedge clock);
        end
        ifRr.out_ready = 1;
        @(posedge clock); #1;
        ifRr.out_ready = 0;
        @(negedge clock);
        waitReady(1, ok);
        @(posedge clock); #1;
        ifRr.req1_valid = 0;
        waitValid(ok, lat);
        total++;
        if (!ok || ifRr.out_data !== 64'hFF || ifRr.out_id !== 1'b1) begin
            bad++; $display("FAIL hold_waiter got ok=%0d d=%h id=%b want d=ff id=1", ok, ifRr.out_data, ifRr.out_id);
        end
        ifRr.out_ready = 1;
        @(posedge clock); #1;
        ifRr.out_ready = 0;
        @(negedge clock);
        runOp(0, 3'd6, 0, 6'd5, 64'hFFFF, d, id, err, lat, ok);
        total++;
        if (!ok || d !== 64'h0 || err !== 1'b1 || lat != 2) begin
            bad++; $display("FAIL illegal_op6 got ok=%0d d=%h err=%b lat=%0d want d=0 err=1 lat=2", ok, d, err, lat);
        end
        runOp(1, 3'd7, 1, 6'd3, 64'h1234, d, id, err, lat, ok);
        total++;
        if (!ok || d !== 64'h0 || err !== 1'b1 || id !== 1'b1) begin
            bad++; $display("FAIL illegal_op7 got ok=%0d d=%h err=%b id=%b want d=0 err=1 id=1", ok, d, err, id);
        end
    endtask

    task automatic test_reset_mid();
        bit ok; int lat;
        logic [63:0] d; logic id, err;
        runOp(1, 3'd0, 0, 6'd0, 64'h1234, d, id, err, lat, ok);
        driveReq(0, 3'd0, 0, 6'd1, 64'h5);
        waitReady(0, ok);
        @(posedge clock); #1;
        ifRr.req0_valid = 0;
        driveReq(1, 3'd0, 0, 6'd0, 64'h7);
        #1 reset_n = 0;
        #1;
        total++;
        if ({ifRr.out_valid, ifRr.busy, ifRr.req0_ready, ifRr.req1_ready, ifRr.out_id, ifRr.out_err} !== 6'b0
            || ifRr.out_data !== 64'h0) begin
            bad++; $display("FAIL reset_async got v=%b b=%b r1=%b d=%h id=%b err=%b want all 0",
                            ifRr.out_valid, ifRr.busy, ifRr.req1_ready, ifRr.out_data, ifRr.out_id, ifRr.out_err);
        end
        @(negedge clock);
        ifRr.req1_valid = 0;
        reset_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            total++;
            if (ifRr.out_valid !== 1'b0 || ifRr.busy !== 1'b0) begin
                bad++; $display("FAIL reset_stale_%0d got v=%b b=%b want 0 0", i, ifRr.out_valid, ifRr.busy);
            end
        end
        driveReq(0, 3'd0, 0, 6'd2, 64'h1);
        driveReq(1, 3'd0, 0, 6'd3, 64'h1);
        #1;
        total++;
        if (ifRr.req0_ready !== 1'b1 || ifRr.req1_ready !== 1'b0) begin
            bad++; $display("FAIL reset_tie got r0=%b r1=%b want r0=1 r1=0", ifRr.req0_ready, ifRr.req1_ready);
        end
        @(posedge clock); #1;
        ifRr.req0_valid = 0; ifRr.req1_valid = 0;
        waitValid(ok, lat);
        total++;
        if (!ok || lat != 2 || ifRr.out_data !== 64'h4 || ifRr.out_id !== 1'b0) begin
            bad++; $display("FAIL reset_next got ok=%0d lat=%0d d=%h id=%b want lat=2 d=4 id=0",
                            ok, lat, ifRr.out_data, ifRr.out_id);
        end
        ifRr.out_ready = 1;
        @(posedge clock); #1;
        ifRr.out_ready = 0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_sll();
        test_dword();
        test_word();
        test_arbitration();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
